// File: rtl/seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_display_ctrl
//  Brief    : Hex 7-segment display controller with static per-digit drive,
//             optional time-multiplexed scan, per-digit blank/blink and
//             leading-zero suppression.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_display_ctrl #(
    parameter int DIGITS     = 8,
    parameter int MUX_MODE   = 0,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 25,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lz_en,
    input  logic                  load,
    output logic [7*DIGITS-1:0]   seg,
    output logic [6:0]            seg_mux,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int c_pw = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int c_bw = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int c_iw = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;

    localparam logic [c_pw-1:0]   c_presc_last = c_pw'(SCAN_DIV - 1);
    localparam logic [c_bw-1:0]   c_blink_last = c_bw'(BLINK_DIV - 1);
    localparam logic [c_iw-1:0]   c_idx_last   = c_iw'(DIGITS - 1);
    // XOR mask doubles as the "all segments off" pattern for either polarity
    localparam logic [6:0]        c_seg_off    = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] c_sel_off    = (ACTIVE_LOW != 0) ? '1 : '0;

    // Active-high segment code for one hex nibble (bit0 = a ... bit6 = g)
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_to_seg = 7'h3F;
            4'h1:    hex_to_seg = 7'h06;
            4'h2:    hex_to_seg = 7'h5B;
            4'h3:    hex_to_seg = 7'h4F;
            4'h4:    hex_to_seg = 7'h66;
            4'h5:    hex_to_seg = 7'h6D;
            4'h6:    hex_to_seg = 7'h7D;
            4'h7:    hex_to_seg = 7'h07;
            4'h8:    hex_to_seg = 7'h7F;
            4'h9:    hex_to_seg = 7'h6F;
            4'hA:    hex_to_seg = 7'h77;
            4'hB:    hex_to_seg = 7'h7C;
            4'hC:    hex_to_seg = 7'h39;
            4'hD:    hex_to_seg = 7'h5E;
            4'hE:    hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    logic [c_pw-1:0]     r_presc;
    logic [c_bw-1:0]     r_blink_cnt;
    logic                r_blink_phase;
    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_blank;
    logic [DIGITS-1:0]   r_blink_en;
    logic                r_lz_en;
    logic [7*DIGITS-1:0] r_seg;

    logic                w_scan_tick;
    logic                w_upper_zero;
    logic [DIGITS-1:0]   w_blank;
    logic [6:0]          w_dig_seg [DIGITS];
    logic [7*DIGITS-1:0] w_seg_next;

    assign w_scan_tick = (r_presc == c_presc_last);

    // Scan prescaler: free-running 0..SCAN_DIV-1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_scan_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_pw'(1);
        end
    end

    // Blink counter: counts scan ticks and flips the blink phase on wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_scan_tick) begin
            if (r_blink_cnt == c_blink_last) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + c_bw'(1);
            end
        end
    end

    // Capture registers: load strobe latches the whole display image at once;
    // reset leaves every digit blanked until the first load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value    <= '0;
            r_blank    <= '1;
            r_blink_en <= '0;
            r_lz_en    <= 1'b0;
        end else if (load) begin
            r_value    <= value;
            r_blank    <= blank_mask;
            r_blink_en <= blink_mask;
            r_lz_en    <= lz_en;
        end
    end

    // Per-digit blank decision; zero-run tracked from the most-significant
    // nibble down, with digit 0 exempt so a zero value still shows "0"
    always_comb begin
        w_upper_zero = 1'b1;
        w_blank      = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_upper_zero = w_upper_zero & (r_value[4*i +: 4] == 4'h0);
            w_blank[i]   = r_blank[i]
                         | (r_blink_en[i] & r_blink_phase)
                         | (r_lz_en & w_upper_zero & (i != 0));
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dec
        assign w_dig_seg[gi] = w_blank[gi] ? c_seg_off
                                           : (hex_to_seg(r_value[4*gi +: 4]) ^ c_seg_off);
        assign w_seg_next[7*gi +: 7] = w_dig_seg[gi];
    end

    // Static segment outputs, one register stage after the capture registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg <= {DIGITS{c_seg_off}};
        end else begin
            r_seg <= w_seg_next;
        end
    end

    assign seg = r_seg;

    if (MUX_MODE != 0) begin : g_mux
        logic [c_iw-1:0]   r_index;     // slot to be shown at the next tick
        logic [c_iw-1:0]   r_disp_idx;  // slot currently shown on dig_sel
        logic              r_started;
        logic [6:0]        r_seg_mux;
        logic [DIGITS-1:0] r_dig_sel;
        logic [c_iw-1:0]   w_mux_idx;
        logic [DIGITS-1:0] w_onehot;

        // On a tick the segment bus follows the incoming slot so that
        // dig_sel and seg_mux switch on the same edge without ghosting
        assign w_mux_idx = w_scan_tick ? r_index : r_disp_idx;

        // One-hot of the slot being brought on at the next tick
        always_comb begin
            w_onehot           = '0;
            w_onehot[r_index]  = 1'b1;
        end

        // Scan sequencer: digit enable and segment bus, refreshed every
        // cycle so a mid-slot load reaches the bus without waiting a slot
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_index    <= '0;
                r_disp_idx <= '0;
                r_started  <= 1'b0;
                r_seg_mux  <= c_seg_off;
                r_dig_sel  <= c_sel_off;
            end else begin
                if (w_scan_tick) begin
                    r_index    <= (r_index == c_idx_last) ? '0 : r_index + c_iw'(1);
                    r_disp_idx <= r_index;
                    r_started  <= 1'b1;
                    r_dig_sel  <= w_onehot ^ c_sel_off;
                end
                r_seg_mux <= (w_scan_tick || r_started) ? w_dig_seg[w_mux_idx] : c_seg_off;
            end
        end

        assign seg_mux = r_seg_mux;
        assign dig_sel = r_dig_sel;
    end else begin : g_static
        assign seg_mux = c_seg_off;
        assign dig_sel = c_sel_off;
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_display_ctrl
//  Brief    : Self-checking bench for seg7_display_ctrl. One DUT scans with
//             active-low outputs, a second runs static-only, active-high.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_display_ctrl;

    localparam int C_SCAN  = 4;
    localparam int C_BLINK = 2;
    // clocks per blink phase after reset release
    localparam int C_PHASE = C_SCAN * C_BLINK;

    typedef struct {
        int          at;
        logic [55:0] seg1;
        logic [55:0] seg0;
        logic [7:0]  sel;
        logic [6:0]  mux;
        bit          chk_mux;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  blank_mask = '0;
    logic [7:0]  blink_mask = '0;
    logic        lz_en = 1'b0;
    logic        load = 1'b0;

    logic [55:0] s1_seg;
    logic [6:0]  s1_mux;
    logic [7:0]  s1_sel;
    logic [55:0] s0_seg;
    logic [6:0]  s0_mux;
    logic [7:0]  s0_sel;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_n   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    seg7_display_ctrl #(
        .DIGITS(8), .MUX_MODE(1), .SCAN_DIV(C_SCAN), .BLINK_DIV(C_BLINK), .ACTIVE_LOW(1)
    ) dut1 (
        .clk(clk), .reset(reset), .value(value), .blank_mask(blank_mask),
        .blink_mask(blink_mask), .lz_en(lz_en), .load(load),
        .seg(s1_seg), .seg_mux(s1_mux), .dig_sel(s1_sel)
    );

    seg7_display_ctrl #(
        .DIGITS(8), .MUX_MODE(0), .SCAN_DIV(C_SCAN), .BLINK_DIV(C_BLINK), .ACTIVE_LOW(0)
    ) dut0 (
        .clk(clk), .reset(reset), .value(value), .blank_mask(blank_mask),
        .blink_mask(blink_mask), .lz_en(lz_en), .load(load),
        .seg(s0_seg), .seg_mux(s0_mux), .dig_sel(s0_sel)
    );

    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        case (nib)
            4'h0: seg_code = 7'h3F;  4'h1: seg_code = 7'h06;
            4'h2: seg_code = 7'h5B;  4'h3: seg_code = 7'h4F;
            4'h4: seg_code = 7'h66;  4'h5: seg_code = 7'h6D;
            4'h6: seg_code = 7'h7D;  4'h7: seg_code = 7'h07;
            4'h8: seg_code = 7'h7F;  4'h9: seg_code = 7'h6F;
            4'hA: seg_code = 7'h77;  4'hB: seg_code = 7'h7C;
            4'hC: seg_code = 7'h39;  4'hD: seg_code = 7'h5E;
            4'hE: seg_code = 7'h79;  default: seg_code = 7'h71;
        endcase
    endfunction

    // Reference image of all eight digits for one polarity
    function automatic logic [55:0] model(input logic [31:0] v, input logic [7:0] bm,
                                          input logic [7:0] blm, input logic lz,
                                          input logic ph, input logic al);
        logic [55:0] r;
        logic        seen;
        logic [3:0]  nib;
        logic [6:0]  d;
        r    = '0;
        seen = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            nib = v[4*i +: 4];
            if (nib != 4'h0 || i == 0) seen = 1'b1;
            d = seg_code(nib);
            if (bm[i] || (blm[i] && ph) || (lz && !seen)) d = 7'h00;
            if (al) d = ~d;
            r[7*i +: 7] = d;
        end
        return r;
    endfunction

    // Expected outputs at edge n after reset release, given the data held
    // in the capture registers at edge n-1
    function automatic exp_t mk(input int n, input logic [31:0] v, input logic [7:0] bm,
                                input logic [7:0] blm, input logic lz);
        exp_t e;
        int   slot;
        logic ph;
        ph     = ((((n - 1) / C_PHASE) % 2) != 0);
        e.at   = n;
        e.seg1 = model(v, bm, blm, lz, ph, 1'b1);
        e.seg0 = model(v, bm, blm, lz, ph, 1'b0);
        if (n < C_SCAN) begin
            e.sel     = 8'hFF;
            e.mux     = 7'h7F;
            e.chk_mux = 1'b0;
        end else begin
            slot      = ((n / C_SCAN) - 1) % 8;
            e.sel     = ~(8'h01 << slot);
            e.mux     = e.seg1[7*slot +: 7];
            e.chk_mux = 1'b1;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        edge_n = 0;
    endtask

    task automatic drive(input logic [31:0] v, input logic [7:0] bm,
                         input logic [7:0] blm, input logic lz);
        value      = v;
        blank_mask = bm;
        blink_mask = blm;
        lz_en      = lz;
        load       = 1'b1;
    endtask

    // Reset forces outputs off at once and the display stays blank with load low
    task automatic test_reset();
        exp_t e;
        value = 32'hDEADBEEF; blank_mask = '0; blink_mask = '0; lz_en = 1'b0; load = 1'b0;
        #1 reset = 1'b1;
        #2;
        n_checks++;
        if (s1_seg !== {8{7'h7F}}) begin n_fail++; $display("FAIL reset seg_al: got %h, want %h", s1_seg, {8{7'h7F}}); end
        n_checks++;
        if (s1_mux !== 7'h7F) begin n_fail++; $display("FAIL reset seg_mux: got %h, want 7f", s1_mux); end
        n_checks++;
        if (s1_sel !== 8'hFF) begin n_fail++; $display("FAIL reset dig_sel: got %h, want ff", s1_sel); end
        n_checks++;
        if (s0_seg !== 56'h0) begin n_fail++; $display("FAIL reset seg_ah: got %h, want 0", s0_seg); end
        do_reset();
        for (int n = 1; n <= 8; n++) sb.push_back(mk(n, 32'h0, 8'hFF, 8'h00, 1'b0));
        for (int k = 0; k < 12 && sb.size() > 0; k++) begin
            value = $urandom(); blank_mask = 8'($urandom()); lz_en = 1'($urandom());
            load  = 1'b0;
            step();
            while (sb.size() > 0 && sb[0].at == edge_n) begin
                e = sb.pop_front();
                n_checks++;
                if (s1_seg !== e.seg1) begin n_fail++; $display("FAIL hold seg_al @%0d: got %h, want %h", edge_n, s1_seg, e.seg1); end
                n_checks++;
                if (s0_seg !== e.seg0) begin n_fail++; $display("FAIL hold seg_ah @%0d: got %h, want %h", edge_n, s0_seg, e.seg0); end
                n_checks++;
                if (s1_sel !== e.sel) begin n_fail++; $display("FAIL hold dig_sel @%0d: got %h, want %h", edge_n, s1_sel, e.sel); end
                if (e.chk_mux) begin
                    n_checks++;
                    if (s1_mux !== e.mux) begin n_fail++; $display("FAIL hold seg_mux @%0d: got %h, want %h", edge_n, s1_mux, e.mux); end
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL hold scoreboard: got %0d left, want 0", sb.size()); sb.delete(); end
    endtask

    // Leading-zero suppression and the two-edge load latency
    task automatic test_leading_zero();
        exp_t e;
        do_reset();
        sb.push_back(mk(2, 32'h000012AF, 8'h00, 8'h00, 1'b1));
        sb.push_back(mk(3, 32'h000012AF, 8'h00, 8'h00, 1'b1));
        sb.push_back(mk(4, 32'h00000000, 8'h00, 8'h00, 1'b1));
        sb.push_back(mk(6, 32'h00000000, 8'h00, 8'h00, 1'b0));
        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            load = 1'b0;
            case (edge_n)
                0:       drive(32'h000012AF, 8'h00, 8'h00, 1'b1);
                2:       drive(32'h00000000, 8'h00, 8'h00, 1'b1);
                4:       drive(32'h00000000, 8'h00, 8'h00, 1'b0);
                default: ;
            endcase
            step();
            while (sb.size() > 0 && sb[0].at == edge_n) begin
                e = sb.pop_front();
                n_checks++;
                if (s1_seg !== e.seg1) begin n_fail++; $display("FAIL lz seg_al @%0d: got %h, want %h", edge_n, s1_seg, e.seg1); end
                n_checks++;
                if (s0_seg !== e.seg0) begin n_fail++; $display("FAIL lz seg_ah @%0d: got %h, want %h", edge_n, s0_seg, e.seg0); end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL lz scoreboard: got %0d left, want 0", sb.size()); sb.delete(); end
    endtask

    // Blinking digit 0 alternates every C_PHASE clocks; others stay lit
    task automatic test_blink();
        exp_t e;
        do_reset();
        for (int n = 2; n <= 26; n++) sb.push_back(mk(n, 32'h88888888, 8'h00, 8'h01, 1'b0));
        for (int k = 0; k < 30 && sb.size() > 0; k++) begin
            load = 1'b0;
            if (edge_n == 0) drive(32'h88888888, 8'h00, 8'h01, 1'b0);
            step();
            while (sb.size() > 0 && sb[0].at == edge_n) begin
                e = sb.pop_front();
                n_checks++;
                if (s1_seg !== e.seg1) begin n_fail++; $display("FAIL blink seg_al @%0d: got %h, want %h", edge_n, s1_seg, e.seg1); end
                n_checks++;
                if (s0_seg !== e.seg0) begin n_fail++; $display("FAIL blink seg_ah @%0d: got %h, want %h", edge_n, s0_seg, e.seg0); end
                if (e.chk_mux) begin
                    n_checks++;
                    if (s1_mux !== e.mux) begin n_fail++; $display("FAIL blink seg_mux @%0d: got %h, want %h", edge_n, s1_mux, e.mux); end
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL blink scoreboard: got %0d left, want 0", sb.size()); sb.delete(); end
    endtask

    // Full scan rotation with wrap; static-only instance keeps its bus idle
    task automatic test_mux_scan();
        exp_t e;
        do_reset();
        for (int n = 1; n <= 40; n++) sb.push_back(mk(n, 32'h76543210, 8'h00, 8'h00, 1'b0));
        for (int k = 0; k < 45 && sb.size() > 0; k++) begin
            load = 1'b0;
            if (edge_n == 0) drive(32'h76543210, 8'h00, 8'h00, 1'b0);
            step();
            while (sb.size() > 0 && sb[0].at == edge_n) begin
                e = sb.pop_front();
                n_checks++;
                if (s1_sel !== e.sel) begin n_fail++; $display("FAIL scan dig_sel @%0d: got %h, want %h", edge_n, s1_sel, e.sel); end
                if (e.chk_mux) begin
                    n_checks++;
                    if (s1_mux !== e.mux) begin n_fail++; $display("FAIL scan seg_mux @%0d: got %h, want %h", edge_n, s1_mux, e.mux); end
                end
                n_checks++;
                if (s0_mux !== 7'h00 || s0_sel !== 8'h00) begin
                    n_fail++;
                    $display("FAIL static idle @%0d: got mux %h sel %h, want 00 00", edge_n, s0_mux, s0_sel);
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scan scoreboard: got %0d left, want 0", sb.size()); sb.delete(); end
    endtask

    // Load coinciding with a scan tick and a blink toggle on the same edge
    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        for (int n = 2; n <= 8; n++)  sb.push_back(mk(n, 32'h0000ABCD, 8'h00, 8'h00, 1'b1));
        for (int n = 9; n <= 12; n++) sb.push_back(mk(n, 32'hFEDCBA98, 8'h00, 8'h04, 1'b0));
        for (int k = 0; k < 16 && sb.size() > 0; k++) begin
            load = 1'b0;
            if (edge_n == 0) drive(32'h0000ABCD, 8'h00, 8'h00, 1'b1);
            if (edge_n == 7) drive(32'hFEDCBA98, 8'h00, 8'h04, 1'b0);
            step();
            while (sb.size() > 0 && sb[0].at == edge_n) begin
                e = sb.pop_front();
                n_checks++;
                if (s1_seg !== e.seg1) begin n_fail++; $display("FAIL b2b seg_al @%0d: got %h, want %h", edge_n, s1_seg, e.seg1); end
                n_checks++;
                if (s1_sel !== e.sel) begin n_fail++; $display("FAIL b2b dig_sel @%0d: got %h, want %h", edge_n, s1_sel, e.sel); end
                if (e.chk_mux) begin
                    n_checks++;
                    if (s1_mux !== e.mux) begin n_fail++; $display("FAIL b2b seg_mux @%0d: got %h, want %h", edge_n, s1_mux, e.mux); end
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL b2b scoreboard: got %0d left, want 0", sb.size()); sb.delete(); end
    endtask

    // Reset mid-slot (index 5, prescaler 2): immediate blanking, clean restart
    task automatic test_reset_midscan();
        exp_t e;
        do_reset();
        for (int n = 2; n <= 22; n++) sb.push_back(mk(n, 32'h76543210, 8'h00, 8'h00, 1'b0));
        for (int k = 0; k < 26 && sb.size() > 0; k++) begin
            load = 1'b0;
            if (edge_n == 0) drive(32'h76543210, 8'h00, 8'h00, 1'b0);
            step();
            while (sb.size() > 0 && sb[0].at == edge_n) begin
                e = sb.pop_front();
                n_checks++;
                if (s1_sel !== e.sel) begin n_fail++; $display("FAIL pre-rst dig_sel @%0d: got %h, want %h", edge_n, s1_sel, e.sel); end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL pre-rst scoreboard: got %0d left, want 0", sb.size()); sb.delete(); end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (s1_seg !== {8{7'h7F}}) begin n_fail++; $display("FAIL async seg_al: got %h, want %h", s1_seg, {8{7'h7F}}); end
        n_checks++;
        if (s1_mux !== 7'h7F) begin n_fail++; $display("FAIL async seg_mux: got %h, want 7f", s1_mux); end
        n_checks++;
        if (s1_sel !== 8'hFF) begin n_fail++; $display("FAIL async dig_sel: got %h, want ff", s1_sel); end
        n_checks++;
        if (s0_seg !== 56'h0) begin n_fail++; $display("FAIL async seg_ah: got %h, want 0", s0_seg); end
        do_reset();
        for (int n = 1; n <= 8; n++) sb.push_back(mk(n, 32'h0, 8'hFF, 8'h00, 1'b0));
        for (int k = 0; k < 12 && sb.size() > 0; k++) begin
            step();
            while (sb.size() > 0 && sb[0].at == edge_n) begin
                e = sb.pop_front();
                n_checks++;
                if (s1_sel !== e.sel) begin n_fail++; $display("FAIL restart dig_sel @%0d: got %h, want %h", edge_n, s1_sel, e.sel); end
                n_checks++;
                if (s1_seg !== e.seg1) begin n_fail++; $display("FAIL restart seg_al @%0d: got %h, want %h", edge_n, s1_seg, e.seg1); end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL restart scoreboard: got %0d left, want 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        test_reset();
        test_leading_zero();
        test_blink();
        test_mux_scan();
        test_back_to_back();
        test_reset_midscan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/seg7_display_ctrl.md
SEG7_DISPLAY_CTRL -- requirements
Module: seg7_display_ctrl

Interface
REQ-001 Parameter DIGITS, 8, number of hex digits (1..16).
REQ-002 Parameter MUX_MODE, 0, 0 = static drive only; 1 = time-multiplexed scan also active.
REQ-003 Parameter SCAN_DIV, 50000, clocks per scan tick (>=2).
REQ-004 Parameter BLINK_DIV, 25, scan ticks per blink phase toggle (>=1).
REQ-005 Parameter ACTIVE_LOW, 1, 1 = segment and digit-select outputs are active-low.
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 value  in  4*DIGITS  hex nibbles; nibble 0 is the least-significant (rightmost) digit.
REQ-009 blank_mask  in  DIGITS  per-digit unconditional blank.
REQ-010 blink_mask  in  DIGITS  per-digit blink enable.
REQ-011 lz_en  in  1  leading-zero suppression enable.
REQ-012 load  in  1  single-cycle strobe that captures value, both masks and lz_en.
REQ-013 seg  out  7*DIGITS  registered static segments; bits [7i+6:7i] drive digit i; bit0 = a ... bit6 = g.
REQ-014 seg_mux  out  7  registered multiplexed segment bus.
REQ-015 dig_sel  out  DIGITS  registered one-hot digit enable.

Function
REQ-016 A rising edge with load=1 SHALL capture all inputs into the active registers, and seg SHALL reflect the new data on the following edge (2-cycle load-to-seg latency).
REQ-017 When load=0, inputs SHALL be ignored.
REQ-018 The prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0, and it SHALL assert an internal scan_tick during count SCAN_DIV-1.
REQ-019 The blink counter SHALL count scan ticks 0..BLINK_DIV-1, and on wrap it SHALL toggle blink_phase.
REQ-020 Decode SHALL use the following active-high codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. ACTIVE_LOW=1 SHALL invert every output bit.
REQ-021 A blanked digit SHALL have all segments off (7'h7F when ACTIVE_LOW=1, 7'h00 otherwise).
REQ-022 A digit SHALL be blanked if any of the following holds:
- its blank_mask bit is 1;
- its blink_mask bit is 1 and blink_phase = 1;
- lz_en = 1 and it and all more-significant nibbles are 0.
REQ-023 Digit 0 SHALL never be blanked by leading-zero suppression, so value 0 displays "0".
REQ-024 When MUX_MODE=1, the index SHALL advance 0..DIGITS-1 on each scan_tick and wrap to 0. dig_sel SHALL be one-hot of the index, and seg_mux SHALL carry that digit's decoded segments. Both SHALL update on the same edge, with no overlap between digits.
REQ-025 When MUX_MODE=0, seg_mux SHALL be held off and dig_sel SHALL be held all inactive.
REQ-026 If load and scan_tick occur in the same cycle, both SHALL take effect: the index advances, and the new data appears on seg_mux one cycle later, within the same scan slot.
REQ-027 If load and a blink toggle occur in the same cycle, both SHALL take effect.

Reset
REQ-028 Reset assertion SHALL immediately force the following:
- prescaler, blink counter, blink_phase and index to 0;
- captured value, blink_mask and lz_en to 0;
- captured blank_mask to all ones.
REQ-029 While reset is asserted, seg and seg_mux SHALL be all off and dig_sel SHALL be all inactive. The display SHALL stay blank until the first load.
REQ-030 Reset asserted in the middle of a scan or blink phase SHALL abandon it, and counting SHALL restart from 0 on the first edge after release.

Verification (DIGITS=8, ACTIVE_LOW=1 unless noted)
REQ-031 Reset pulse -> the following values:
- seg = all digits 7'h7F;
- seg_mux = 7'h7F;
- dig_sel = 8'hFF;
- these hold until the first load.
REQ-032 Load value=32'h000012AF, lz_en=1, masks=0 -> two edges later the digits read as follows:
- digit0 = 7'h0E;
- digit1 = 7'h08;
- digit2 = 7'h24;
- digit3 = 7'h79;
- digits 4..7 = 7'h7F.
REQ-033 Load value=0, lz_en=1 -> digit0 = 7'h40 and digits 1..7 = 7'h7F. Then load with lz_en=0 -> all digits = 7'h40.
REQ-034 SCAN_DIV=4, BLINK_DIV=2, load value=32'h88888888, blink_mask=8'h01 -> digit0 alternates 7'h00 / 7'h7F every 8 clocks, and the other digits stay 7'h00.
REQ-035 MUX_MODE=1, SCAN_DIV=4 -> dig_sel steps 8'hFE, FD, FB, F7, EF, DF, BF, 7F, then back to FE. Each step lasts 4 clocks, and seg_mux matches the selected digit.
REQ-036 Reset asserted at index 5 with the prescaler at 2 -> outputs go off asynchronously. After release, dig_sel = 8'hFE after the first scan tick (SCAN_DIV clocks).
